// File: rtl/reg_writeback_arbiter_pkg.sv
// Register-file geometry and the writeback entry shared by the execute, memory
// and writeback stages.
package reg_writeback_arbiter_pkg;
  localparam int DATA_WIDTH    = 32;
  localparam int SEL_WIDTH     = 4;
  localparam int NUM_REGISTERS = 1 << SEL_WIDTH;

  typedef struct packed {
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_arbiter_skid_fifo.sv
// Small in-order buffer for ALU results that lose the write port to a load.
// A push and a pop may share an edge even when the buffer is full.
module wb_skid_fifo
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [NUM_REGISTERS-1:0] dest_mask
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr, rd_ptr, count;
  logic [AW-1:0] wr_idx, rd_idx;
  wb_entry_t     mem [DEPTH];

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign count  = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head   = mem[rd_idx];

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && (!full || pop)) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)          rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push && (!full || pop)) mem[wr_idx] <= push_entry;
  end

  // Destination bits of every occupied slot, for the hazard mask.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dest_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] offs;
      offs = AW'(i) - rd_idx;
      if ({1'b0, offs} < count) dest_mask[mem[i].sel] = 1'b1;
    end
  end
endmodule

// File: rtl/reg_writeback_arbiter.sv
// Owns the register file write port: loads first, then buffered ALU results,
// then bypassed ALU results. Also tracks loads in flight for decode stalls.
module reg_writeback_arbiter
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_alu_valid,
  output logic                     in_alu_ready,
  input  logic [SEL_WIDTH-1:0]     in_alu_sel,
  input  logic [DATA_WIDTH-1:0]    in_alu_data,
  input  logic                     in_claim_en,
  input  logic [SEL_WIDTH-1:0]     in_claim_sel,
  input  logic                     in_load_valid,
  input  logic [SEL_WIDTH-1:0]     in_load_sel,
  input  logic [DATA_WIDTH-1:0]    in_load_data,
  output logic                     out_write_en,
  output logic [SEL_WIDTH-1:0]     out_write_sel,
  output logic [DATA_WIDTH-1:0]    out_write_data,
  output logic [NUM_REGISTERS-1:0] out_busy,
  output logic                     out_err_unclaimed
);
  logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                     sel_fifo, sel_bypass, any_sel;
  logic [NUM_REGISTERS-1:0] fifo_mask, scoreboard, sb_next, wr_mask;
  wb_entry_t                fifo_head, alu_entry, next_entry;

  assign alu_entry = '{sel: in_alu_sel, data: in_alu_data};

  wb_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (alu_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .dest_mask  (fifo_mask)
  );

  // Loads cannot stall, so they always win; buffered ALU results keep ALU order.
  assign sel_fifo     = !in_load_valid && !fifo_empty;
  assign sel_bypass   = !in_load_valid && fifo_empty && in_alu_valid;
  assign any_sel      = in_load_valid || sel_fifo || sel_bypass;
  assign fifo_pop     = sel_fifo;
  assign in_alu_ready = !fifo_full || fifo_pop;
  assign fifo_push    = in_alu_valid && in_alu_ready && !sel_bypass;

  always_comb begin
    next_entry = alu_entry;
    if (in_load_valid) next_entry = '{sel: in_load_sel, data: in_load_data};
    else if (sel_fifo) next_entry = fifo_head;
  end

  // A claim arriving with a same-register writeback is a newer load, so set wins.
  always_comb begin
    sb_next = scoreboard;
    if (in_load_valid)                        sb_next[in_load_sel]  = 1'b0;
    if (in_claim_en && in_claim_sel != '0)    sb_next[in_claim_sel] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_write_en      <= 1'b0;
      out_write_sel     <= '0;
      out_write_data    <= '0;
      scoreboard        <= '0;
      out_err_unclaimed <= 1'b0;
    end else begin
      out_write_en <= any_sel && (next_entry.sel != '0);
      if (any_sel) begin
        out_write_sel  <= next_entry.sel;
        out_write_data <= next_entry.data;
      end
      scoreboard <= sb_next;
      if (in_load_valid && in_load_sel != '0 && !scoreboard[in_load_sel])
        out_err_unclaimed <= 1'b1;
    end
  end

  always_comb begin
    wr_mask = '0;
    if (out_write_en) wr_mask[out_write_sel] = 1'b1;
  end

  assign out_busy = (scoreboard | fifo_mask | wr_mask) & {{(NUM_REGISTERS-1){1'b1}}, 1'b0};
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter: arbitration order, FIFO backpressure,
// scoreboard set/clear, r0 handling, unclaimed-load error and mid-flight reset.
module tb_reg_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_alu_valid, in_alu_ready;
  logic [3:0]  in_alu_sel;
  logic [31:0] in_alu_data;
  logic        in_claim_en;
  logic [3:0]  in_claim_sel;
  logic        in_load_valid;
  logic [3:0]  in_load_sel;
  logic [31:0] in_load_data;
  logic        out_write_en;
  logic [3:0]  out_write_sel;
  logic [31:0] out_write_data;
  logic [15:0] out_busy;
  logic        out_err_unclaimed;

  int n_cmp = 0;
  int n_bad = 0;

  reg_writeback_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_alu_valid      (in_alu_valid),
    .in_alu_ready      (in_alu_ready),
    .in_alu_sel        (in_alu_sel),
    .in_alu_data       (in_alu_data),
    .in_claim_en       (in_claim_en),
    .in_claim_sel      (in_claim_sel),
    .in_load_valid     (in_load_valid),
    .in_load_sel       (in_load_sel),
    .in_load_data      (in_load_data),
    .out_write_en      (out_write_en),
    .out_write_sel     (out_write_sel),
    .out_write_data    (out_write_data),
    .out_busy          (out_busy),
    .out_err_unclaimed (out_err_unclaimed)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then read 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_alu_valid = 0; in_alu_sel = 0; in_alu_data = 0;
    in_claim_en = 0; in_claim_sel = 0;
    in_load_valid = 0; in_load_sel = 0; in_load_data = 0;
  endtask

  task automatic alu(input logic [3:0] s, input logic [31:0] d);
    in_alu_valid = 1; in_alu_sel = s; in_alu_data = d;
  endtask

  task automatic load(input logic [3:0] s, input logic [31:0] d);
    in_load_valid = 1; in_load_sel = s; in_load_data = d;
  endtask

  task automatic claim(input logic [3:0] s);
    in_claim_en = 1; in_claim_sel = s;
  endtask

  task automatic expect_write(input string name, input logic en,
                              input logic [3:0] s, input logic [31:0] d);
    n_cmp++;
    if ({out_write_en, out_write_sel, out_write_data} !== {en, s, d}) begin
      n_bad++;
      $display("FAIL %s: got en=%0b sel=%0d data=%h, want en=%0b sel=%0d data=%h",
               name, out_write_en, out_write_sel, out_write_data, en, s, d);
    end
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    tick(); tick();
    expect_write("reset_write", 0, 0, 0);
    n_cmp++;
    if ({out_busy, out_err_unclaimed} !== 17'h0) begin
      n_bad++; $display("FAIL reset_busy_err: got busy=%h err=%0b, want 0/0", out_busy, out_err_unclaimed);
    end
    rst = 0;
    alu(3, 32'h11);
    tick();
    expect_write("bypass_r3", 1, 3, 32'h11);
    idle();
    tick();
    expect_write("idle_hold", 0, 3, 32'h11);
  endtask

  task automatic test_load_priority();
    claim(5);
    tick();
    idle();
    load(5, 32'hAA); alu(2, 32'h22);
    #1;
    n_cmp++;
    if (in_alu_ready !== 1'b1) begin
      n_bad++; $display("FAIL prio_ready: got %0b, want 1", in_alu_ready);
    end
    tick();
    expect_write("prio_load_r5", 1, 5, 32'hAA);
    n_cmp++;
    if (out_busy !== 16'h0024) begin
      n_bad++; $display("FAIL prio_busy: got %h, want 0024", out_busy);
    end
    idle();
    tick();
    expect_write("prio_alu_r2", 1, 2, 32'h22);
    n_cmp++;
    if (out_err_unclaimed !== 1'b0) begin
      n_bad++; $display("FAIL prio_err: got %0b, want 0", out_err_unclaimed);
    end
  endtask

  task automatic test_fifo_fill();
    claim(10); tick();
    claim(11); tick();
    claim(12); tick();
    idle();
    load(10, 32'hA0); alu(1, 32'h1);
    tick();
    expect_write("fill_load_r10", 1, 10, 32'hA0);
    load(11, 32'hB0); alu(2, 32'h2);
    tick();
    expect_write("fill_load_r11", 1, 11, 32'hB0);
    load(12, 32'hC0); alu(4, 32'h4);
    #1;
    n_cmp++;
    if (in_alu_ready !== 1'b0) begin
      n_bad++; $display("FAIL fill_ready_full: got %0b, want 0", in_alu_ready);
    end
    tick();
    expect_write("fill_load_r12", 1, 12, 32'hC0);
    in_load_valid = 0;
    #1;
    n_cmp++;
    if (in_alu_ready !== 1'b1) begin
      n_bad++; $display("FAIL fill_ready_pop: got %0b, want 1", in_alu_ready);
    end
    tick();
    expect_write("drain_r1", 1, 1, 32'h1);
    idle();
    tick();
    expect_write("drain_r2", 1, 2, 32'h2);
    tick();
    expect_write("drain_r4", 1, 4, 32'h4);
    tick();
    expect_write("drain_done", 0, 4, 32'h4);
  endtask

  task automatic test_scoreboard();
    claim(7);
    tick();
    n_cmp++;
    if (out_busy !== 16'h0080) begin
      n_bad++; $display("FAIL sb_claim: got busy=%h, want 0080", out_busy);
    end
    load(7, 32'h77);
    tick();
    n_cmp++;
    if (out_busy[7] !== 1'b1) begin
      n_bad++; $display("FAIL sb_set_wins: got busy[7]=%0b, want 1", out_busy[7]);
    end
    idle();
    tick();
    n_cmp++;
    if (out_busy !== 16'h0080) begin
      n_bad++; $display("FAIL sb_still_busy: got busy=%h, want 0080", out_busy);
    end
    load(7, 32'h78);
    tick();
    expect_write("sb_load_r7", 1, 7, 32'h78);
    idle();
    tick();
    n_cmp++;
    if ({out_busy, out_err_unclaimed} !== 17'h0) begin
      n_bad++; $display("FAIL sb_cleared: got busy=%h err=%0b, want 0/0", out_busy, out_err_unclaimed);
    end
  endtask

  task automatic test_r0_and_err();
    alu(0, 32'h55);
    tick();
    expect_write("r0_no_write", 0, 0, 32'h55);
    idle();
    tick();
    expect_write("r0_consumed", 0, 0, 32'h55);
    claim(0);
    tick();
    idle();
    n_cmp++;
    if (out_busy !== 16'h0) begin
      n_bad++; $display("FAIL r0_claim: got busy=%h, want 0", out_busy);
    end
    load(9, 32'h99);
    tick();
    expect_write("unclaimed_r9", 1, 9, 32'h99);
    n_cmp++;
    if (out_err_unclaimed !== 1'b1) begin
      n_bad++; $display("FAIL err_set: got %0b, want 1", out_err_unclaimed);
    end
    idle();
    tick(); tick();
    n_cmp++;
    if (out_err_unclaimed !== 1'b1) begin
      n_bad++; $display("FAIL err_sticky: got %0b, want 1", out_err_unclaimed);
    end
  endtask

  task automatic test_reset_mid();
    claim(13); tick();
    claim(14); tick();
    idle();
    load(13, 32'hD0); alu(1, 32'h101); claim(4);
    tick();
    idle();
    load(14, 32'hE0); alu(2, 32'h202);
    tick();
    idle();
    n_cmp++;
    if (out_busy !== 16'h4016) begin
      n_bad++; $display("FAIL mid_busy_before: got %h, want 4016", out_busy);
    end
    rst = 1;
    tick();
    expect_write("mid_reset_write", 0, 0, 0);
    n_cmp++;
    if ({out_busy, out_err_unclaimed, in_alu_ready} !== 18'h1) begin
      n_bad++; $display("FAIL mid_reset_state: got busy=%h err=%0b ready=%0b, want 0/0/1",
                        out_busy, out_err_unclaimed, in_alu_ready);
    end
    rst = 0;
    tick();
    expect_write("mid_after_reset", 0, 0, 0);
    n_cmp++;
    if (out_busy !== 16'h0) begin
      n_bad++; $display("FAIL mid_after_busy: got %h, want 0", out_busy);
    end
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_load_priority();
    test_fifo_fill();
    test_scoreboard();
    test_r0_and_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
